instruction_encoder: RTL and testbench
======================================

# instruction_encoder

Inverse of the instruction decoder. Accepts an operation select plus register/immediate fields through a valid/ready handshake and produces the 32-bit RV32I instruction word the decoder consumes. Output words are tagged with an incrementing byte address so the test-program loader can write them straight into instruction memory. Illegal requests are rejected and counted.

## Interface
- ADDR_W, 10, width of the output byte-address counter.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted on a cycle where in_valid && in_ready.
- op_sel  input  5  operation index:
  - 0..5: beq, bne, blt, bge, bltu, bgeu.
  - 6..14: addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
  - 15..24: add, sub, sll, slt, sltu, xor, srl, sra, or, and.
  - 25..31: illegal.
- rd, rs1, rs2  input  5 each  register fields.
- imm  input  13  signed immediate; the branch byte offset for B-type, imm[11:0] for I-type.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  downstream accepts the word.
- instruction_code  output  32  encoded word.
- out_addr  output  ADDR_W  byte address of the current output word.
- err_pulse  output  1  one-cycle pulse when an illegal request is dropped.
- err_count  output  8  saturating count of dropped requests.

## Operation
- Two-stage pipeline.
  - S1 registers the request and classifies it: type, funct3, funct7 bit 30, legality.
  - S2 holds the assembled instruction_code.
- Encoding:
  - B-type: opcode 1100011. Fields are imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11]. funct3 values: beq 000, bne 001, blt 100, bge 101, bltu 110, bgeu 111. rd is ignored.
  - I-type: opcode 0010011. Fields are imm[11:0], rs1, funct3, rd. funct3 values: addi 000, slti 010, sltiu 011, xori 100, ori 110, andi 111. imm[12] is ignored.
  - Shifts (slli 001, srli 101, srai 101): bits [24:20] = imm[4:0], bits [31:25] = 0000000, or 0100000 for srai.
  - R-type: opcode 0110011. Fields are funct7, rs2, rs1, funct3, rd. funct7 = 0100000 for sub and sra, otherwise 0000000. funct3 values: add/sub 000, sll 001, slt 010, sltu 011, xor 100, srl/sra 101, or 110, and 111.
  - Unused fields (rs2 for I-type, rd for B-type) contribute nothing; their bits come from the immediate or are zero.
- Illegal requests:
  - A request is illegal if any of these holds: op_sel ≥ 25; a branch with imm[0] = 1; a shift with imm[11:5] ≠ 0.
  - An illegal request is still accepted (in_ready behaves normally). It does not advance to S2, produces no output, and leaves out_addr unchanged.
  - err_pulse goes high the cycle after the request leaves S1.
  - err_count increments and saturates at 255.
- Addressing:
  - out_addr starts at 0.
  - It increments by 4 on each output handshake (out_valid && out_ready).
  - It wraps modulo 2^ADDR_W.

## Timing
- Reset values: in_ready 1, out_valid 0, instruction_code 0, out_addr 0, err_pulse 0, err_count 0. Both stage-valid flags are cleared.
- Reset mid-operation drops in-flight requests. No output is produced for them.
- Latency: a request accepted at edge N sets out_valid after edge N+1. instruction_code is stable from then until the handshake.
- Throughput: one instruction per cycle while out_ready = 1.
- Handshake rules:
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = S1 advances. This is a combinational path from out_ready and is permitted.
- While out_valid = 1 and out_ready = 0, instruction_code and out_addr must hold.
- Pipeline full (both stages valid, out_ready = 0): in_ready = 0.
- Simultaneous events: an output handshake and a new input acceptance in the same cycle both take effect.
- An illegal request in S1 always advances (it never needs S2), unless the pipeline is held by reset.

## Test plan
- Basic encodes, each with rd/rs fields as listed and out_ready = 1; each appears one cycle after acceptance:
  - addi x1,x0,5 → 0x00500093 at out_addr 0.
  - sub x3,x1,x2 → 0x402081B3 at out_addr 4.
- Branch and shift:
  - beq x1,x2,+8 → 0x00208463.
  - srai x5,x6,3 → 0x40335293.
  - bgeu x0,x0,-4 → 0xFE007EE3.
- Illegal requests: op_sel 27, then beq with imm = 3, then slli with imm = 0x020.
  - Each is accepted with no output, one err_pulse per request.
  - err_count ends at 3; out_addr unchanged.
- Backpressure: issue 4 back-to-back legal requests with out_ready held 0.
  - in_ready drops after 2 are accepted; instruction_code is stable.
  - Release out_ready: all 4 words emerge in order at out_addr 0, 4, 8, 12.
- Wrap and saturation:
  - ADDR_W = 4: 5 outputs produce out_addr 0, 4, 8, 12, 0.
  - 260 illegal requests leave err_count = 255.
- Reset mid-stream: assert rst with both stages valid.
  - Next cycle: out_valid 0, out_addr 0, err_count 0, in_ready 1.

Source files
------------

// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: op select + fields -> 32-bit word.
// Two-stage valid/ready pipeline with address tagging and error count.
module instruction_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [12:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instruction_code,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_pulse,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {
    T_BR  = 2'd0,
    T_IMM = 2'd1,
    T_SH  = 2'd2,
    T_REG = 2'd3
  } itype_e;

  typedef struct packed {
    itype_e      ty;
    logic [2:0]  f3;
    logic        f7b;
    logic        legal;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
  } s1_t;

  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_REG = 7'b0110011;

  s1_t               w_s1_next;
  s1_t               r_s1;
  logic              r_s1_valid;
  logic              r_s2_valid;
  logic [31:0]       r_code;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err_pulse;
  logic [7:0]        r_err_count;
  logic [31:0]       w_code;
  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_s1_err;
  logic              w_out_fire;

  // Classify the incoming request: type, funct3, funct7[5], legality
  always_comb begin
    w_s1_next     = '0;
    w_s1_next.ty  = T_REG;
    w_s1_next.f3  = 3'b000;
    w_s1_next.f7b = 1'b0;
    w_s1_next.legal = 1'b1;
    w_s1_next.rd  = rd;
    w_s1_next.rs1 = rs1;
    w_s1_next.rs2 = rs2;
    w_s1_next.imm = imm;
    case (op_sel)
      5'd0:  begin w_s1_next.ty = T_BR;  w_s1_next.f3 = 3'b000; end
      5'd1:  begin w_s1_next.ty = T_BR;  w_s1_next.f3 = 3'b001; end
      5'd2:  begin w_s1_next.ty = T_BR;  w_s1_next.f3 = 3'b100; end
      5'd3:  begin w_s1_next.ty = T_BR;  w_s1_next.f3 = 3'b101; end
      5'd4:  begin w_s1_next.ty = T_BR;  w_s1_next.f3 = 3'b110; end
      5'd5:  begin w_s1_next.ty = T_BR;  w_s1_next.f3 = 3'b111; end
      5'd6:  begin w_s1_next.ty = T_IMM; w_s1_next.f3 = 3'b000; end
      5'd7:  begin w_s1_next.ty = T_IMM; w_s1_next.f3 = 3'b010; end
      5'd8:  begin w_s1_next.ty = T_IMM; w_s1_next.f3 = 3'b011; end
      5'd9:  begin w_s1_next.ty = T_IMM; w_s1_next.f3 = 3'b100; end
      5'd10: begin w_s1_next.ty = T_IMM; w_s1_next.f3 = 3'b110; end
      5'd11: begin w_s1_next.ty = T_IMM; w_s1_next.f3 = 3'b111; end
      5'd12: begin w_s1_next.ty = T_SH;  w_s1_next.f3 = 3'b001; end
      5'd13: begin w_s1_next.ty = T_SH;  w_s1_next.f3 = 3'b101; end
      5'd14: begin
        w_s1_next.ty  = T_SH;
        w_s1_next.f3  = 3'b101;
        w_s1_next.f7b = 1'b1;
      end
      5'd15: w_s1_next.f3 = 3'b000;
      5'd16: begin w_s1_next.f3 = 3'b000; w_s1_next.f7b = 1'b1; end
      5'd17: w_s1_next.f3 = 3'b001;
      5'd18: w_s1_next.f3 = 3'b010;
      5'd19: w_s1_next.f3 = 3'b011;
      5'd20: w_s1_next.f3 = 3'b100;
      5'd21: w_s1_next.f3 = 3'b101;
      5'd22: begin w_s1_next.f3 = 3'b101; w_s1_next.f7b = 1'b1; end
      5'd23: w_s1_next.f3 = 3'b110;
      5'd24: w_s1_next.f3 = 3'b111;
      default: w_s1_next.legal = 1'b0;
    endcase
    if (w_s1_next.ty == T_BR && imm[0])
      w_s1_next.legal = 1'b0;
    if (w_s1_next.ty == T_SH && imm[11:5] != 7'd0)
      w_s1_next.legal = 1'b0;
  end

  // Assemble the instruction word from the classified S1 contents
  always_comb begin
    w_code = '0;
    unique case (r_s1.ty)
      T_BR: w_code = {r_s1.imm[12], r_s1.imm[10:5],
                      r_s1.rs2, r_s1.rs1, r_s1.f3,
                      r_s1.imm[4:1], r_s1.imm[11], OPC_BR};
      T_IMM: w_code = {r_s1.imm[11:0], r_s1.rs1,
                       r_s1.f3, r_s1.rd, OPC_IMM};
      T_SH: w_code = {1'b0, r_s1.f7b, 5'd0, r_s1.imm[4:0],
                      r_s1.rs1, r_s1.f3, r_s1.rd, OPC_IMM};
      T_REG: w_code = {1'b0, r_s1.f7b, 5'd0, r_s1.rs2,
                       r_s1.rs1, r_s1.f3, r_s1.rd, OPC_REG};
      default: w_code = '0;
    endcase
  end

  // Stage advance: illegal entries never need S2, so they always drain
  always_comb begin
    w_s1_err   = r_s1_valid && !r_s1.legal;
    w_s2_adv   = !r_s2_valid || out_ready;
    w_s1_adv   = !r_s1_valid || w_s2_adv || w_s1_err;
    w_out_fire = r_s2_valid && out_ready;
  end

  // S1 request register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      r_s1       <= w_s1_next;
    end
  end

  // S2 holds the assembled word until the output handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_code     <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid && r_s1.legal;
      if (r_s1_valid && r_s1.legal)
        r_code <= w_code;
    end
  end

  // Output byte address, advances by one word per handshake
  always_ff @(posedge clk) begin
    if (rst)
      r_addr <= '0;
    else if (w_out_fire)
      r_addr <= r_addr + ADDR_W'(4);
  end

  // Error pulse and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_s1_err;
      if (w_s1_err && r_err_count != 8'hFF)
        r_err_count <= r_err_count + 8'd1;
    end
  end

  assign in_ready         = w_s1_adv;
  assign out_valid        = r_s2_valid;
  assign instruction_code = r_code;
  assign out_addr         = r_addr;
  assign err_pulse        = r_err_pulse;
  assign err_count        = r_err_count;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed testbench for instruction_encoder.
// Two instances share stimulus; the second uses a 4-bit address.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op_sel;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [12:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction_code;
  logic [9:0]  out_addr;
  logic        err_pulse;
  logic [7:0]  err_count;

  logic        in_ready4;
  logic        out_valid4;
  logic [31:0] code4;
  logic [3:0]  addr4;
  logic        errp4;
  logic [7:0]  errc4;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  instruction_encoder #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .instruction_code(instruction_code), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  instruction_encoder #(.ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4),
    .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid4), .out_ready(out_ready),
    .instruction_code(code4), .out_addr(addr4),
    .err_pulse(errp4), .err_count(errc4)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [4:0] o, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2,
                         input logic [12:0] im);
    op_sel = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0;
    step; step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    out_ready = 1'b0;
    set_req(5'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    do_reset;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready);
    else n_pass++;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid);
    else n_pass++;
    n_total++;
    if (instruction_code !== 32'h0)
      $display("FAIL rst_code got %h want 00000000", instruction_code);
    else n_pass++;
    n_total++;
    if (out_addr !== 10'd0) $display("FAIL rst_addr got %0d want 0", out_addr);
    else n_pass++;
    n_total++;
    if (err_pulse !== 1'b0) $display("FAIL rst_err_pulse got %b want 0", err_pulse);
    else n_pass++;
    n_total++;
    if (err_count !== 8'd0) $display("FAIL rst_err_count got %0d want 0", err_count);
    else n_pass++;
    n_total++;
    if (in_ready4 !== 1'b1 || errp4 !== 1'b0)
      $display("FAIL rst_dut4 got in_ready=%b err_pulse=%b want 1 0", in_ready4, errp4);
    else n_pass++;
  endtask

  // Legal encodes, one at a time with out_ready high
  task automatic test_encodes;
    logic [4:0]  t_op  [5] = '{5'd6, 5'd16, 5'd0, 5'd14, 5'd5};
    logic [4:0]  t_rd  [5] = '{5'd1, 5'd3,  5'd0, 5'd5,  5'd0};
    logic [4:0]  t_rs1 [5] = '{5'd0, 5'd1,  5'd1, 5'd6,  5'd0};
    logic [4:0]  t_rs2 [5] = '{5'd0, 5'd2,  5'd2, 5'd0,  5'd0};
    logic [12:0] t_imm [5] = '{13'd5, 13'd0, 13'd8, 13'd3, 13'h1FFC};
    logic [31:0] t_exp [5] = '{32'h00500093, 32'h402081B3,
                               32'h00208463, 32'h40335293, 32'hFE007EE3};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_req(t_op[i], t_rd[i], t_rs1[i], t_rs2[i], t_imm[i]);
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      n_total++;
      if (out_valid !== 1'b0)
        $display("FAIL enc%0d_early got out_valid=%b want 0", i, out_valid);
      else n_pass++;
      step;
      n_total++;
      if (out_valid !== 1'b1 || instruction_code !== t_exp[i])
        $display("FAIL enc%0d_code got v=%b %h want v=1 %h",
                 i, out_valid, instruction_code, t_exp[i]);
      else n_pass++;
      n_total++;
      if (out_addr !== 10'(4 * i))
        $display("FAIL enc%0d_addr got %0d want %0d", i, out_addr, 4 * i);
      else n_pass++;
      step;
    end
  endtask

  task automatic test_illegal;
    logic [4:0]  t_op  [3] = '{5'd27, 5'd0, 5'd12};
    logic [12:0] t_imm [3] = '{13'd0, 13'd3, 13'h020};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(t_op[i], 5'd1, 5'd2, 5'd3, t_imm[i]);
      in_valid = 1'b1;
      #1;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL ill%0d_ready got %b want 1", i, in_ready);
      else n_pass++;
      step;
      in_valid = 1'b0;
      step;
      n_total++;
      if (err_pulse !== 1'b1 || out_valid !== 1'b0)
        $display("FAIL ill%0d_pulse got pulse=%b v=%b want 1 0", i, err_pulse, out_valid);
      else n_pass++;
      step;
      n_total++;
      if (err_pulse !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL ill%0d_after got pulse=%b v=%b want 0 0", i, err_pulse, out_valid);
      else n_pass++;
    end
    n_total++;
    if (err_count !== 8'd3) $display("FAIL ill_count got %0d want 3", err_count);
    else n_pass++;
    n_total++;
    if (out_addr !== 10'd20) $display("FAIL ill_addr got %0d want 20", out_addr);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [31:0] t_exp [4] = '{32'h00100093, 32'h00200093,
                               32'h00300093, 32'h00400093};
    int k_in;
    int k_out;
    logic fire_in;
    do_reset;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(5'd6, 5'd1, 5'd0, 5'd0, 13'(i + 1));
      in_valid = 1'b1;
      #1;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL bp_acc%0d got in_ready=%b want 1", i, in_ready);
      else n_pass++;
      step;
    end
    set_req(5'd6, 5'd1, 5'd0, 5'd0, 13'd3);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL bp_full%0d got in_ready=%b want 0", c, in_ready);
      else n_pass++;
      n_total++;
      if (out_valid !== 1'b1 || instruction_code !== t_exp[0])
        $display("FAIL bp_hold%0d got v=%b %h want v=1 %h",
                 c, out_valid, instruction_code, t_exp[0]);
      else n_pass++;
      step;
    end
    k_in = 2;
    k_out = 0;
    out_ready = 1'b1;
    #1;
    for (int c = 0; c < 20 && k_out < 4; c++) begin
      if (out_valid) begin
        n_total++;
        if (instruction_code !== t_exp[k_out] || out_addr !== 10'(4 * k_out))
          $display("FAIL bp_out%0d got %h@%0d want %h@%0d", k_out,
                   instruction_code, out_addr, t_exp[k_out], 4 * k_out);
        else n_pass++;
        k_out++;
      end
      fire_in = in_valid && in_ready;
      step;
      if (fire_in) begin
        k_in++;
        if (k_in < 4) set_req(5'd6, 5'd1, 5'd0, 5'd0, 13'(k_in + 1));
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_total++;
    if (k_out !== 4) $display("FAIL bp_timeout got %0d words want 4", k_out);
    else n_pass++;
  endtask

  task automatic test_wrap;
    logic [3:0] t_addr [5] = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd0};
    do_reset;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_req(5'd15, 5'd1, 5'd2, 5'd3, 13'd0);
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      step;
      n_total++;
      if (out_valid4 !== 1'b1 || addr4 !== t_addr[i] || code4 !== 32'h003100B3)
        $display("FAIL wrap%0d got v=%b %h@%0d want v=1 003100b3@%0d",
                 i, out_valid4, code4, addr4, t_addr[i]);
      else n_pass++;
      step;
    end
  endtask

  task automatic test_saturation;
    do_reset;
    out_ready = 1'b1;
    set_req(5'd27, 5'd0, 5'd0, 5'd0, 13'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 260; i++) step;
    in_valid = 1'b0;
    step; step; step;
    n_total++;
    if (err_count !== 8'd255) $display("FAIL sat_count got %0d want 255", err_count);
    else n_pass++;
    n_total++;
    if (errc4 !== 8'd255) $display("FAIL sat_count4 got %0d want 255", errc4);
    else n_pass++;
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b1;
    set_req(5'd6, 5'd1, 5'd0, 5'd0, 13'd5);
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    step; step;
    out_ready = 1'b0;
    in_valid = 1'b1;
    step; step;
    #1;
    n_total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_addr !== 10'd4)
      $display("FAIL mid_pre got v=%b rdy=%b addr=%0d want 1 0 4",
               out_valid, in_ready, out_addr);
    else n_pass++;
    in_valid = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || out_addr !== 10'd0 ||
        err_count !== 8'd0 || in_ready !== 1'b1)
      $display("FAIL mid_post got v=%b addr=%0d cnt=%0d rdy=%b want 0 0 0 1",
               out_valid, out_addr, err_count, in_ready);
    else n_pass++;
    out_ready = 1'b1;
    step; step;
    n_total++;
    if (out_valid !== 1'b0 || out_addr !== 10'd0)
      $display("FAIL mid_drop got v=%b addr=%0d want 0 0", out_valid, out_addr);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    test_reset;
    test_encodes;
    test_illegal;
    test_backpressure;
    test_wrap;
    test_saturation;
    test_reset_midstream;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
